// File: rtl/zad7_1_pkg.sv
// rtl/zad7_1_pkg.sv - binary16 field widths, constants and the packed half-float layout
package zad7_1_pkg;

  localparam int F16_EXP_W = 5;
  localparam int F16_MAN_W = 10;
  localparam int F16_BIAS  = 15;

  localparam logic [15:0] F16_POS_INF = 16'h7C00;
  localparam logic [15:0] F16_ZERO    = 16'h0000;

  typedef struct packed {
    logic                 sign;
    logic [F16_EXP_W-1:0] exp;
    logic [F16_MAN_W-1:0] man;
  } f16_t;

endpackage

// File: rtl/zad7_1_lzc16.sv
// rtl/zad7_1_lzc16.sv - combinational 16-bit leading-zero counter with all-zero flag
module lzc16 (
  input  logic [15:0] i_data,
  output logic [3:0]  o_count,
  output logic        o_zero
);

  // Ascending scan: the highest set bit is the last one to write the count.
  always_comb begin
    o_count = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (i_data[i]) o_count = 4'(15 - i);
    end
  end

  assign o_zero = ~|i_data;

endmodule

// File: rtl/zad7_1.sv
// rtl/zad7_1.sv - registered 16-bit integer to binary16 converter, RNE rounding, +inf clamp
// Define ZAD7_1_SIGNED_EN to treat input0 as two's complement.
import zad7_1_pkg::*;

module zad7_1 (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] input0,
  output logic [15:0] output0
);

  logic        w_sign;
  logic [15:0] w_mag;
  logic [3:0]  w_lz;
  logic        w_zero;
  logic [14:0] w_norm;
  logic [9:0]  w_man_t;
  logic        w_guard;
  logic        w_sticky;
  logic        w_round_up;
  logic [10:0] w_man_sum;
  logic [5:0]  w_exp;
  f16_t        w_res;
  f16_t        r_out;

`ifdef ZAD7_1_SIGNED_EN
  assign w_sign = input0[15];
  assign w_mag  = input0[15] ? 16'(-input0) : input0;
`else
  assign w_sign = 1'b0;
  assign w_mag  = input0;
`endif

  lzc16 u_lzc (
    .i_data  (w_mag),
    .o_count (w_lz),
    .o_zero  (w_zero)
  );

  // Shift the leading one out of the top; what remains is mantissa, guard, sticky.
  assign w_norm     = 15'(w_mag << w_lz);
  assign w_man_t    = w_norm[14:5];
  assign w_guard    = w_norm[4];
  assign w_sticky   = |w_norm[3:0];
  assign w_round_up = w_guard & (w_sticky | w_man_t[0]);
  assign w_man_sum  = {1'b0, w_man_t} + 11'(w_round_up);
  assign w_exp      = 6'(F16_BIAS) + 6'(4'd15 - w_lz) + 6'(w_man_sum[10]);

  always_comb begin
    w_res = f16_t'(F16_ZERO);
    if (!w_zero) begin
      if (w_exp >= 6'd31) begin
        w_res = f16_t'({w_sign, F16_POS_INF[14:0]});
      end else begin
        w_res.sign = w_sign;
        w_res.exp  = w_exp[4:0];
        w_res.man  = w_man_sum[9:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_out <= f16_t'(F16_ZERO);
    else     r_out <= w_res;
  end

  assign output0 = r_out;

endmodule

// File: tb/tb_zad7_1.sv
// tb/tb_zad7_1.sv - directed and random checks of zad7_1 against a real-arithmetic model
module tb_zad7_1;

  logic        clk;
  logic        rst;
  logic [15:0] input0;
  logic [15:0] output0;

  int errors = 0;
  int checks = 0;

  zad7_1 dut (
    .clk     (clk),
    .rst     (rst),
    .input0  (input0),
    .output0 (output0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Value-level model: scale to [1,2), round the 10 fraction bits with real math.
  function automatic logic [15:0] model(input logic [15:0] x);
    int  m;
    logic s;
    int  e;
    real p2;
    real scaled;
    real r;
    real diff;
    int  man;
    int  ex;
`ifdef ZAD7_1_SIGNED_EN
    s = x[15];
    m = s ? 65536 - int'(x) : int'(x);
`else
    s = 1'b0;
    m = int'(x);
`endif
    if (m == 0) return 16'h0000;
    e  = 0;
    p2 = 1.0;
    while (p2 * 2.0 <= real'(m)) begin
      p2 = p2 * 2.0;
      e++;
    end
    scaled = (real'(m) / p2 - 1.0) * 1024.0;
    r      = $floor(scaled);
    diff   = scaled - r;
    man    = int'(r);
    if (diff > 0.5 || (diff == 0.5 && (man % 2) == 1)) man++;
    if (man == 1024) begin
      man = 0;
      e++;
    end
    ex = e + 15;
    if (ex >= 31) return {s, 15'h7C00};
    return {s, 5'(ex), 10'(man)};
  endfunction

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply(input string tag, input logic [15:0] x);
    @(negedge clk);
    input0 = x;
    @(posedge clk);
    #1;
    check(tag, output0, model(x));
  endtask

  initial begin
    logic [15:0] v;
    rst    = 1'b1;
    input0 = 16'h1234;
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold", output0, 16'h0000);

    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("first_after_reset", output0, model(16'h1234));
    check("first_const", output0, 16'h6C8D);

    apply("three", 16'd3);
    check("three_const", output0, 16'h4200);
    apply("one", 16'd1);
    check("one_const", output0, 16'h3C00);
    apply("zero", 16'd0);
    check("zero_const", output0, 16'h0000);
    apply("p1024", 16'd1024);
    check("p1024_const", output0, 16'h6400);

    apply("tie_even_2049", 16'd2049);
    check("tie_2049_const", output0, 16'h6800);
    apply("tie_odd_2051", 16'd2051);
    check("tie_2051_const", output0, 16'h6802);
    apply("tie_even_2053", 16'd2053);
    check("tie_2053_const", output0, 16'h6802);
    apply("exact_2047", 16'd2047);
    apply("carry_4095", 16'd4095);
    check("carry_4095_const", output0, 16'h6C00);

`ifndef ZAD7_1_SIGNED_EN
    apply("top_65504", 16'd65504);
    check("top_65504_const", output0, 16'h7BFF);
    apply("top_65519", 16'd65519);
    check("top_65519_const", output0, 16'h7BFF);
    apply("inf_65520", 16'd65520);
    check("inf_65520_const", output0, 16'h7C00);
    apply("inf_65535", 16'd65535);
    check("inf_65535_const", output0, 16'h7C00);
`else
    apply("neg3", 16'hFFFD);
    check("neg3_const", output0, 16'hC200);
    apply("min_neg", 16'h8000);
    check("min_neg_const", output0, 16'hF800);
    apply("max_pos", 16'h7FFF);
    check("max_pos_const", output0, 16'h7800);
`endif

    for (int i = 0; i < 300; i++) begin
      case (i % 4)
        0: v = 16'($urandom_range(0, 65535));
        1: v = 16'($urandom_range(65400, 65535));
        2: v = 16'($urandom_range(0, 4200));
        default: v = 16'($urandom) >> $urandom_range(0, 15);
      endcase
      apply("random", v);
    end

    // Reset asserted between edges must clear the output without a clock edge.
    @(negedge clk);
    input0 = 16'd12345;
    @(posedge clk);
    #1;
    check("pre_async", output0, model(16'd12345));
    #2;
    rst = 1'b1;
    #1;
    check("async_clear", output0, 16'h0000);
    @(posedge clk);
    #1;
    check("async_held", output0, 16'h0000);
    @(negedge clk);
    rst    = 1'b0;
    input0 = 16'd777;
    @(posedge clk);
    #1;
    check("after_async", output0, model(16'd777));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
